// File: rtl/alu_exec_unit.sv
// ALU execute stage: registered results, one-cycle ops, shifts via barrel or serial.
// Define ALU_SERIAL_SHIFT_EN for one-bit-per-cycle shifts through the SHIFT state.
module alu_exec_unit #(
  parameter int NB_DATA   = 32,
  parameter int NB_ALU_OP = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  input  logic [NB_ALU_OP-1:0] i_alu_operation,
  input  logic                 i_shamt_ctrl,
  input  logic [4:0]           i_shamt,
  input  logic [NB_DATA-1:0]   i_data_a,
  input  logic [NB_DATA-1:0]   i_data_b,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [NB_DATA-1:0]   o_result,
  output logic                 o_zero,
  output logic                 o_overflow
);

  localparam logic [NB_ALU_OP-1:0] OP_ADD = NB_ALU_OP'(0);
  localparam logic [NB_ALU_OP-1:0] OP_SUB = NB_ALU_OP'(1);
  localparam logic [NB_ALU_OP-1:0] OP_AND = NB_ALU_OP'(2);
  localparam logic [NB_ALU_OP-1:0] OP_OR  = NB_ALU_OP'(3);
  localparam logic [NB_ALU_OP-1:0] OP_XOR = NB_ALU_OP'(4);
  localparam logic [NB_ALU_OP-1:0] OP_NOR = NB_ALU_OP'(5);
  localparam logic [NB_ALU_OP-1:0] OP_SLT = NB_ALU_OP'(6);
  localparam logic [NB_ALU_OP-1:0] OP_SLL = NB_ALU_OP'(7);
  localparam logic [NB_ALU_OP-1:0] OP_SRL = NB_ALU_OP'(8);
  localparam logic [NB_ALU_OP-1:0] OP_SRA = NB_ALU_OP'(9);
  localparam logic [NB_ALU_OP-1:0] OP_BNE = NB_ALU_OP'(10);
  localparam int MSB = NB_DATA - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [NB_DATA-1:0]   sum;
  logic [NB_DATA-1:0]   diff;
  logic [NB_DATA-1:0]   res_c;
  logic                 ovf_c;
  logic                 is_shift;
  logic [4:0]           shamt;
  logic [NB_ALU_OP-1:0] op;
  logic [NB_DATA-1:0]   a;
  logic [NB_DATA-1:0]   b;

  assign op      = i_alu_operation;
  assign a       = i_data_a;
  assign b       = i_data_b;
  assign shamt   = i_shamt_ctrl ? i_shamt : i_data_a[4:0];
  assign sum     = a + b;
  assign diff    = a - b;
  assign o_ready = (state == IDLE);

  always_comb begin
    res_c    = '0;
    ovf_c    = 1'b0;
    is_shift = 1'b0;
    unique case (1'b1)
      op == OP_ADD: begin
        res_c = sum;
        ovf_c = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      op == OP_SUB: begin
        res_c = diff;
        ovf_c = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      op == OP_AND: res_c = a & b;
      op == OP_OR:  res_c = a | b;
      op == OP_XOR: res_c = a ^ b;
      op == OP_NOR: res_c = ~(a | b);
      op == OP_SLT: res_c = {{MSB{1'b0}}, ($signed(a) < $signed(b))};
      op == OP_BNE: res_c = {{MSB{1'b0}}, (a == b)};
      op == OP_SLL: begin
        res_c    = b << shamt;
        is_shift = 1'b1;
      end
      op == OP_SRL: begin
        res_c    = b >> shamt;
        is_shift = 1'b1;
      end
      op == OP_SRA: begin
        res_c    = $signed(b) >>> shamt;
        is_shift = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ALU_SERIAL_SHIFT_EN
  logic [NB_ALU_OP-1:0] sh_op;
  logic [NB_DATA-1:0]   sh_data;
  logic [NB_DATA-1:0]   sh_next;
  logic [NB_DATA-1:0]   first_c;
  logic [4:0]           cnt;

  function automatic logic [NB_DATA-1:0] shift1(
    input logic [NB_ALU_OP-1:0] f_op,
    input logic [NB_DATA-1:0]   x
  );
    if (f_op == OP_SLL)
      return {x[MSB-1:0], 1'b0};
    else if (f_op == OP_SRA)
      return {x[MSB], x[MSB:1]};
    else
      return {1'b0, x[MSB:1]};
  endfunction

  // Accepting edge already does bit one; N=0 passes B through.
  assign first_c = (shamt == 5'd0) ? b : shift1(op, b);
  assign sh_next = shift1(sh_op, sh_data);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      o_valid    <= 1'b0;
      o_result   <= '0;
      o_zero     <= 1'b1;
      o_overflow <= 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
      cnt        <= 5'd0;
      sh_op      <= '0;
      sh_data    <= '0;
`endif
    end else begin
      o_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_valid) begin
`ifdef ALU_SERIAL_SHIFT_EN
            if (is_shift && shamt > 5'd1) begin
              sh_op   <= op;
              sh_data <= first_c;
              cnt     <= shamt - 5'd1;
              state   <= SHIFT;
            end else if (is_shift) begin
              o_valid    <= 1'b1;
              o_result   <= first_c;
              o_zero     <= (first_c == '0);
              o_overflow <= 1'b0;
            end else begin
`else
            begin
`endif
              o_valid    <= 1'b1;
              o_result   <= res_c;
              o_zero     <= (res_c == '0);
              o_overflow <= ovf_c;
            end
          end
        end
        default: begin
`ifdef ALU_SERIAL_SHIFT_EN
          sh_data <= sh_next;
          cnt     <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            o_valid    <= 1'b1;
            o_result   <= sh_next;
            o_zero     <= (sh_next == '0);
            o_overflow <= 1'b0;
            state      <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed literal cases plus random traffic
// checked every cycle against a latency/arithmetic reference model.
module tb_alu_exec_unit;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] AND = 4'd2;
  localparam logic [3:0] OR  = 4'd3;
  localparam logic [3:0] XOR = 4'd4;
  localparam logic [3:0] NOR = 4'd5;
  localparam logic [3:0] SLT = 4'd6;
  localparam logic [3:0] SLL = 4'd7;
  localparam logic [3:0] SRL = 4'd8;
  localparam logic [3:0] SRA = 4'd9;
  localparam logic [3:0] BNE = 4'd10;

`ifdef ALU_SERIAL_SHIFT_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv;
  logic [3:0]  op;
  logic        shc;
  logic [4:0]  sh;
  logic [31:0] a;
  logic [31:0] b;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_zero;
  logic        o_overflow;

  int passed = 0;
  int total  = 0;
  bit chk_on = 1'b0;

  alu_exec_unit #(.NB_DATA(32), .NB_ALU_OP(4)) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_valid(iv),
    .i_alu_operation(op),
    .i_shamt_ctrl(shc),
    .i_shamt(sh),
    .i_data_a(a),
    .i_data_b(b),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_result(o_result),
    .o_zero(o_zero),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] f_op,
    input logic [31:0] x, input logic [31:0] y, input logic [4:0] n);
    case (f_op)
      ADD: return x + y;
      SUB: return x - y;
      AND: return x & y;
      OR:  return x | y;
      XOR: return x ^ y;
      NOR: return ~(x | y);
      SLT: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      BNE: return (x == y) ? 32'd1 : 32'd0;
      SLL: return y << n;
      SRL: return y >> n;
      SRA: return 32'($signed(y) >>> n);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [3:0] f_op,
    input logic [31:0] x, input logic [31:0] y);
    longint s;
    if (f_op == ADD) s = longint'($signed(x)) + longint'($signed(y));
    else if (f_op == SUB) s = longint'($signed(x)) - longint'($signed(y));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic int ref_lat(input logic [3:0] f_op, input logic [4:0] n);
    if (SERIAL && (f_op == SLL || f_op == SRL || f_op == SRA))
      return (n == 5'd0) ? 1 : int'(n);
    return 1;
  endfunction

  // Reference model: a result appears lat cycles after accept; busy blocks accepts.
  logic [4:0]  cur_n;
  int          m_busy;
  logic        m_valid;
  logic [31:0] m_res;
  logic [31:0] m_pend;
  logic        m_zero;
  logic        m_ovf;
  logic        m_ready;

  assign cur_n   = shc ? sh : a[4:0];
  assign m_ready = (m_busy == 0);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_res   <= 32'd0;
      m_zero  <= 1'b1;
      m_ovf   <= 1'b0;
      m_busy  <= 0;
    end else if (m_busy != 0) begin
      m_busy  <= m_busy - 1;
      m_valid <= (m_busy == 1);
      if (m_busy == 1) begin
        m_res  <= m_pend;
        m_zero <= (m_pend == 32'd0);
        m_ovf  <= 1'b0;
      end
    end else if (iv) begin
      if (ref_lat(op, cur_n) == 1) begin
        m_valid <= 1'b1;
        m_res   <= ref_res(op, a, b, cur_n);
        m_zero  <= (ref_res(op, a, b, cur_n) == 32'd0);
        m_ovf   <= ref_ovf(op, a, b);
      end else begin
        m_valid <= 1'b0;
        m_busy  <= ref_lat(op, cur_n) - 1;
        m_pend  <= ref_res(op, a, b, cur_n);
      end
    end else begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready", {31'd0, o_ready}, {31'd0, m_ready});
      chk("valid", {31'd0, o_valid}, {31'd0, m_valid});
      chk("result", o_result, m_res);
      chk("zero", {31'd0, o_zero}, {31'd0, m_zero});
      chk("ovf", {31'd0, o_overflow}, {31'd0, m_ovf});
    end
  end

  task automatic drive(input logic v, input logic [3:0] f_op,
    input logic c, input logic [4:0] s,
    input logic [31:0] x, input logic [31:0] y);
    iv  = v;
    op  = f_op;
    shc = c;
    sh  = s;
    a   = x;
    b   = y;
  endtask

  initial begin
    int k;
    int low;
    int vcount;
    rst_n = 1'b0;
    drive(1'b0, ADD, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_zero", {31'd0, o_zero}, 32'd1);
    chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    drive(1'b1, ADD, 1'b0, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    iv = 1'b0;
    chk("add_valid", {31'd0, o_valid}, 32'd1);
    chk("add_result", o_result, 32'h8000_0000);
    chk("add_ovf", {31'd0, o_overflow}, 32'd1);
    chk("add_zero", {31'd0, o_zero}, 32'd0);

    drive(1'b1, SLT, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    drive(1'b1, BNE, 1'b0, 5'd0, 32'd5, 32'd5);
    chk("slt_valid", {31'd0, o_valid}, 32'd1);
    chk("slt_result", o_result, 32'd1);
    chk("slt_zero", {31'd0, o_zero}, 32'd0);
    @(negedge clk);
    iv = 1'b0;
    chk("bne_valid", {31'd0, o_valid}, 32'd1);
    chk("bne_result", o_result, 32'd1);
    chk("bne_zero", {31'd0, o_zero}, 32'd0);
    @(negedge clk);

    drive(1'b1, SRA, 1'b1, 5'd4, 32'h1234_5678, 32'h8000_0000);
    @(negedge clk);
    iv  = 1'b0;
    k   = 1;
    low = 0;
    while (!o_valid && k < 40) begin
      if (!o_ready) low++;
      @(negedge clk);
      k++;
    end
    chk("sra_latency", k, SERIAL ? 32'd4 : 32'd1);
    chk("sra_ready_low", low, SERIAL ? 32'd3 : 32'd0);
    chk("sra_result", o_result, 32'hF800_0000);
    @(negedge clk);

    drive(1'b1, SLL, 1'b0, 5'd0, 32'h0000_0023, 32'h0000_0001);
    @(negedge clk);
    k = 1;
    while (!o_valid && k < 40) begin
      drive(1'b1, OR, 1'b0, 5'd0, 32'hFFFF_0000, 32'h0000_FFFF);
      @(negedge clk);
      k++;
    end
    iv = 1'b0;
    chk("sll_latency", k, SERIAL ? 32'd3 : 32'd1);
    chk("sll_result", o_result, 32'h0000_0008);
    @(negedge clk);

    drive(1'b1, SRL, 1'b1, 5'd10, 32'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    iv = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("srl_rst_result", o_result, 32'd0);
    chk("srl_rst_zero", {31'd0, o_zero}, 32'd1);
    rst_n  = 1'b1;
    vcount = 0;
    @(negedge clk);
    chk("srl_rst_ready", {31'd0, o_ready}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      if (o_valid) vcount++;
      @(negedge clk);
    end
    chk("srl_abort_novalid", vcount, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      iv    = ($urandom_range(0, 9) < 7);
      op    = 4'($urandom_range(0, 15));
      shc   = 1'($urandom);
      sh    = 5'($urandom);
      case ($urandom_range(0, 3))
        0: a = 32'h7FFF_FFFF;
        1: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = 32'h0000_0001;
        default: b = $urandom;
      endcase
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The module SHALL have parameter NB_DATA, default 32, meaning operand/result width.
REQ-002 The module SHALL have parameter NB_ALU_OP, default 4, meaning width of the ALU operation code defined in execute_constants.vh.
REQ-003 The module SHALL have port i_clk  input  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 The module SHALL have port i_reset_n  input  1  reset, synchronous and active-low.
REQ-005 The module SHALL have port i_valid  input  1  request strobe; the operation is accepted on a rising edge where i_valid=1 and o_ready=1.
REQ-006 The module SHALL have port i_alu_operation  input  NB_ALU_OP  operation code from alu_control (`ADD, `SUB, `AND, `OR, `XOR, `NOR, `SLT, `SLL, `SRL, `SRA, `BNE).
REQ-007 The module SHALL have port i_shamt_ctrl  input  1  shift-amount source: 1 selects i_shamt, 0 selects i_data_a[4:0].
REQ-008 The module SHALL have port i_shamt  input  5  instruction shift amount.
REQ-009 The module SHALL have port i_data_a  input  NB_DATA  operand A (rs).
REQ-010 The module SHALL have port i_data_b  input  NB_DATA  operand B (rt; the shifted operand for shifts).
REQ-011 The module SHALL have port o_ready  output  1  unit can accept a request this cycle.
REQ-012 The module SHALL have port o_valid  output  1  one-cycle pulse marking a new o_result.
REQ-013 The module SHALL have port o_result  output  NB_DATA  registered result, held until the next result.
REQ-014 The module SHALL have port o_zero  output  1  registered, equals (o_result == 0).
REQ-015 The module SHALL have port o_overflow  output  1  registered signed overflow, `ADD/`SUB only, else 0.

Function
REQ-016 ADD/SUB SHALL be two's-complement modulo 2^NB_DATA; AND/OR/XOR/NOR bitwise; SLT SHALL return 1 if signed A<B else 0; BNE SHALL return 1 if A==B else 0, so o_zero=1 means operands differ.
REQ-017 SLL/SRL SHALL shift B by amount N with zero fill; SRA SHALL replicate B's MSB.
REQ-018 Unknown operation codes SHALL produce o_result=0, o_overflow=0, with normal o_valid timing.
REQ-019 The FSM SHALL have states IDLE and SHIFT; o_ready=1 exactly when in IDLE.
REQ-020 Non-shift operations SHALL have latency 1: o_valid high for the single cycle immediately after the accepting edge; the FSM stays in IDLE.
REQ-021 i_valid while o_ready=0 SHALL be ignored (not queued); inputs SHALL be sampled only on the accepting edge.
REQ-022 An accept SHALL be allowed in the same cycle o_valid is high (back-to-back, one result per cycle for non-shift ops).
REQ-023 o_result, o_zero and o_overflow SHALL update only together with an o_valid pulse and hold otherwise.

Reset
REQ-024 While i_reset_n=0 at a rising edge, the unit SHALL enter IDLE with o_valid=0, o_result=0, o_zero=1, o_overflow=0, shift counter=0; o_ready SHALL be 1 in the following cycle.
REQ-025 Reset during SHIFT SHALL abort the operation; no o_valid SHALL be produced for it.

Configuration
REQ-026 With macro ALU_SERIAL_SHIFT_EN defined, shifts SHALL execute one bit per cycle: the accepting edge performs the first bit and loads a counter with max(N,1)-1; the FSM enters SHIFT if the counter is nonzero, shifting one bit per edge and asserting o_valid in the cycle after the edge that completes bit N, then returning to IDLE; latency = max(1,N) cycles; N=0 SHALL yield B unchanged with latency 1.
REQ-027 Without ALU_SERIAL_SHIFT_EN, shifts SHALL use a single-cycle barrel shifter with latency 1, the SHIFT state SHALL be unreachable and o_ready SHALL stay 1 after reset.

Verification
REQ-028 `ADD A=0x7FFFFFFF B=0x00000001 -> next cycle o_valid=1, o_result=0x80000000, o_overflow=1, o_zero=0.
REQ-029 `SLT A=0xFFFFFFFF B=0x00000001 then back-to-back `BNE A=5 B=5 -> results 1 then 1 on consecutive cycles, o_zero=0 both.
REQ-030 `SRA i_shamt_ctrl=1 i_shamt=4 B=0x80000000 with ALU_SERIAL_SHIFT_EN -> o_ready low 3 cycles, o_valid 4 cycles after accept, o_result=0xF8000000; without macro -> latency 1, same result.
REQ-031 `SLL i_shamt_ctrl=0 A=0x00000023 B=0x00000001 (N=3) with macro, i_valid held high with a new `OR during SHIFT -> OR ignored, o_result=0x00000008.
REQ-032 Reset asserted in 2nd SHIFT cycle of `SRL N=10 -> no o_valid, o_result=0, o_zero=1, o_ready=1 one cycle after reset release.
